irq_dispatch: RTL and testbench



---
 rtl/irq_pkg.sv | 13 +
 rtl/prio_stack.sv | 54 +++++
 rtl/irq_dispatch.sv | 94 +++++++++
 tb/tb_irq_dispatch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: dispatch FSM states and
// default widths shared with the priority tree and pending/priority registers.
package irq_pkg;

   localparam int unsigned TREE_WIDTH_DEF = 8;
   localparam int unsigned PRIO_WIDTH_DEF = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } dispatch_state_e;

endpackage

// File: rtl/prio_stack.sv
// LIFO of active handler priority levels. A push and a pop in the same cycle
// replaces the top entry (pop first, then push).
module prio_stack
   import irq_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = PRIO_WIDTH_DEF,
   localparam int unsigned SpWidth = $clog2(Depth + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [Width-1:0]   push_data,
   output logic [Width-1:0]   top,
   output logic [SpWidth-1:0] depth,
   output logic               full,
   output logic               empty
);

   localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0]     mem [Depth];
   logic [SpWidth-1:0]   sp;
   logic                 do_pop;
   logic                 do_push;
   logic [AddrWidth-1:0] top_addr;
   logic [AddrWidth-1:0] push_addr;

   assign empty     = (sp == SpWidth'(0));
   assign full      = (sp == SpWidth'(Depth));
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign top_addr  = AddrWidth'(sp - SpWidth'(1));
   assign push_addr = do_pop ? top_addr : AddrWidth'(sp);
   assign top       = empty ? '0 : mem[top_addr];
   assign depth     = sp;

   always_ff @(posedge clk) begin
      if (reset) begin
         sp <= '0;
      end else begin
         sp <= sp + SpWidth'(do_push) - SpWidth'(do_pop);
      end
   end

   // Storage carries no reset; entries above sp are never observed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[push_addr] <= push_data;
      end
   end

endmodule

// File: rtl/irq_dispatch.sv
// Dispatch stage after the max-select priority tree: offers a strictly
// higher-priority winner to the core and tracks nested handler levels.
module irq_dispatch
   import irq_pkg::*;
#(
   parameter int unsigned TreeWidth  = TREE_WIDTH_DEF,
   parameter int unsigned PrioWidth  = PRIO_WIDTH_DEF,
   parameter int unsigned StackDepth = 4,
   localparam int unsigned IdxWidth  = $clog2(TreeWidth),
   localparam int unsigned SpWidth   = $clog2(StackDepth + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IdxWidth-1:0]  winner_id,
   input  logic [PrioWidth-1:0] winner_prio,
   output logic                 req_valid,
   output logic [IdxWidth-1:0]  req_id,
   output logic [PrioWidth-1:0] req_prio,
   input  logic                 req_ready,
   input  logic                 ret,
   output logic                 clr_valid,
   output logic [IdxWidth-1:0]  clr_id,
   output logic [PrioWidth-1:0] cur_prio,
   output logic [SpWidth-1:0]   depth
);

   dispatch_state_e state;
   dispatch_state_e next_state;
   logic            load_req;
   logic            xfer;
   logic            stk_full;
   logic            stk_empty;

   prio_stack #(
      .Depth (StackDepth),
      .Width (PrioWidth)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (xfer),
      .pop       (ret && !stk_empty),
      .push_data (req_prio),
      .top       (cur_prio),
      .depth     (depth),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // Strict compare also blocks a re-offer of the just-cleared source,
   // whose priority equals the new running level.
   always_comb begin
      next_state = state;
      load_req   = 1'b0;
      xfer       = 1'b0;
      case (state)
         IDLE: begin
            if ((winner_prio > cur_prio) && !stk_full) begin
               load_req   = 1'b1;
               next_state = OFFER;
            end
         end
         OFFER: begin
            if (req_ready) begin
               xfer       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_valid <= 1'b0;
         req_id    <= '0;
         req_prio  <= '0;
         clr_valid <= 1'b0;
         clr_id    <= '0;
      end else begin
         state     <= next_state;
         req_valid <= (next_state == OFFER);
         clr_valid <= xfer;
         if (load_req) begin
            req_id   <= winner_id;
            req_prio <= winner_prio;
         end
         if (xfer) begin
            clr_id <= req_id;
         end
      end
   end

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch: a vector table for dispatch, nesting, ties,
// simultaneous ret/transfer and reset, plus sequences for stall and full stack.
module tb_irq_dispatch;

   localparam int unsigned IW = 3;
   localparam int unsigned PW = 8;
   localparam int unsigned SW = 3;
   localparam int NVEC = 18;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [IW-1:0] winner_id = '0;
   logic [PW-1:0] winner_prio = '0;
   logic          req_ready = 1'b0;
   logic          ret = 1'b0;
   logic          req_valid;
   logic [IW-1:0] req_id;
   logic [PW-1:0] req_prio;
   logic          clr_valid;
   logic [IW-1:0] clr_id;
   logic [PW-1:0] cur_prio;
   logic [SW-1:0] depth;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic          rst;
      logic [IW-1:0] wid;
      logic [PW-1:0] wprio;
      logic          rdy;
      logic          rt;
      logic          ev;
      logic [IW-1:0] eid;
      logic [PW-1:0] eprio;
      logic          ecv;
      logic [IW-1:0] ecid;
      logic [PW-1:0] ecur;
      logic [SW-1:0] edep;
   } vec_t;

   vec_t vecs [NVEC];

   irq_dispatch dut (
      .clk         (clk),
      .reset       (reset),
      .winner_id   (winner_id),
      .winner_prio (winner_prio),
      .req_valid   (req_valid),
      .req_id      (req_id),
      .req_prio    (req_prio),
      .req_ready   (req_ready),
      .ret         (ret),
      .clr_valid   (clr_valid),
      .clr_id      (clr_id),
      .cur_prio    (cur_prio),
      .depth       (depth)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0d expected %0d", name, tag, act, exp);
      end
   endtask

   task automatic drive(input logic [IW-1:0] id, input logic [PW-1:0] pr, input logic rdy, input logic rt);
      winner_id   = id;
      winner_prio = pr;
      req_ready   = rdy;
      ret         = rt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string name, input int tag, input logic ev, input logic [IW-1:0] eid,
                            input logic [PW-1:0] eprio, input logic ecv, input logic [IW-1:0] ecid,
                            input logic [PW-1:0] ecur, input logic [SW-1:0] edep, input logic chk_req);
      chk({name, ".req_valid"}, tag, 32'(req_valid), 32'(ev));
      if (ev || chk_req) begin
         chk({name, ".req_id"}, tag, 32'(req_id), 32'(eid));
         chk({name, ".req_prio"}, tag, 32'(req_prio), 32'(eprio));
      end
      chk({name, ".clr_valid"}, tag, 32'(clr_valid), 32'(ecv));
      if (ecv || chk_req) chk({name, ".clr_id"}, tag, 32'(clr_id), 32'(ecid));
      chk({name, ".cur_prio"}, tag, 32'(cur_prio), 32'(ecur));
      chk({name, ".depth"}, tag, 32'(depth), 32'(edep));
   endtask

   initial begin
      //          rst wid pri rdy ret  ev eid epri ecv ecid ecur edep
      vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};  // reset
      vecs[1]  = '{0, 3, 5, 1, 0,   1, 3, 5, 0, 0, 0, 0};  // offer id3/5
      vecs[2]  = '{0, 3, 5, 1, 0,   0, 0, 0, 1, 3, 5, 1};  // transfer, clear
      vecs[3]  = '{0, 3, 5, 1, 0,   0, 0, 0, 0, 0, 5, 1};  // stale winner: no re-offer
      vecs[4]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 5, 1};
      vecs[5]  = '{0, 4, 5, 0, 0,   0, 0, 0, 0, 0, 5, 1};  // tie never preempts
      vecs[6]  = '{0, 1, 7, 0, 0,   1, 1, 7, 0, 0, 5, 1};
      vecs[7]  = '{0, 1, 7, 1, 0,   0, 0, 0, 1, 1, 7, 2};  // nested
      vecs[8]  = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 5, 1};
      vecs[9]  = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0};
      vecs[10] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0};  // ret on empty ignored
      vecs[11] = '{0, 5, 6, 1, 0,   1, 5, 6, 0, 0, 0, 0};
      vecs[12] = '{0, 0, 0, 1, 0,   0, 0, 0, 1, 5, 6, 1};
      vecs[13] = '{0, 2, 8, 0, 0,   1, 2, 8, 0, 0, 6, 1};
      vecs[14] = '{0, 0, 0, 1, 1,   0, 0, 0, 1, 2, 8, 1};  // ret + transfer
      vecs[15] = '{0, 7, 9, 0, 0,   1, 7, 9, 0, 0, 8, 1};
      vecs[16] = '{1, 7, 9, 1, 0,   0, 0, 0, 0, 0, 0, 0};  // reset mid-offer
      vecs[17] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < NVEC; i++) begin
         reset = vecs[i].rst;
         drive(vecs[i].wid, vecs[i].wprio, vecs[i].rdy, vecs[i].rt);
         step();
         chk_state("vec", i, vecs[i].ev, vecs[i].eid, vecs[i].eprio, vecs[i].ecv,
                   vecs[i].ecid, vecs[i].ecur, vecs[i].edep, vecs[i].rst);
      end

      // Stall: offer held stable while the upstream winner changes.
      reset = 1'b0;
      drive(2, 9, 0, 0);
      step();
      chk_state("stall_offer", 0, 1, 2, 9, 0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         drive(6, 12, 0, 0);
         step();
         chk_state("stall_hold", c, 1, 2, 9, 0, 0, 0, 0, 0);
      end
      drive(6, 12, 1, 0);
      step();
      chk_state("stall_xfer", 0, 0, 0, 0, 1, 2, 9, 1, 0);
      drive(6, 12, 0, 0);
      step();
      chk_state("stall_next", 0, 1, 6, 12, 0, 0, 9, 1, 0);
      drive(6, 12, 1, 0);
      step();
      chk_state("stall_next_xfer", 0, 0, 0, 0, 1, 6, 12, 2, 0);
      drive(0, 0, 0, 1);
      step();
      drive(0, 0, 0, 1);
      step();
      chk_state("stall_unwind", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Full stack: four nested levels, then a higher winner must wait for a ret.
      for (int p = 1; p <= 4; p++) begin
         drive(IW'(p), PW'(p), 1, 0);
         step();
         chk_state("fill_offer", p, 1, IW'(p), PW'(p), 0, 0, PW'(p - 1), SW'(p - 1), 0);
         drive(0, 0, 1, 0);
         step();
         chk_state("fill_xfer", p, 0, 0, 0, 1, IW'(p), PW'(p), SW'(p), 0);
      end
      for (int c = 0; c < 3; c++) begin
         drive(7, 10, 1, 0);
         step();
         chk_state("full_block", c, 0, 0, 0, 0, 0, 4, 4, 0);
      end
      drive(7, 10, 1, 1);
      step();
      chk_state("full_pop", 0, 0, 0, 0, 0, 0, 3, 3, 0);
      drive(7, 10, 1, 0);
      step();
      chk_state("full_offer", 0, 1, 7, 10, 0, 0, 3, 3, 0);
      drive(0, 0, 1, 0);
      step();
      chk_state("full_xfer", 0, 0, 0, 0, 1, 7, 10, 4, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
